// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use, redirect flush, memory wait and halt
// sequencing, with a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rstB,
    input  logic             imem_valid,
    input  logic [4:0]       if_reg_s1,
    input  logic [4:0]       if_reg_s2,
    input  logic             ex_op_memLd,
    input  logic [4:0]       ex_reg_d,
    input  logic             redirect,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    input  logic             ex_ecb,
    input  logic             resume,
    output logic             pc_en,
    output logic             dec_clkEn,
    output logic             dec_jmp,
    output logic             ex_hold,
    output logic             stall,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [2:0] {
        RUN      = 3'd0,
        LU_STALL = 3'd1,
        FLUSH    = 3'd2,
        MEM_WAIT = 3'd3,
        HALT     = 3'd4
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [2:0] flush_cnt_reg, flush_cnt_next;
    logic       lu_pend_reg, lu_pend_next;
    logic       lu;
    logic       run_eval;

    assign lu = imem_valid & ex_op_memLd & (ex_reg_d != 5'd0) &
                ((ex_reg_d == if_reg_s1) | (ex_reg_d == if_reg_s2));

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        lu_pend_next   = lu_pend_reg;
        run_eval       = 1'b0;
        case (state_reg)
            RUN, LU_STALL: run_eval = 1'b1;
            FLUSH: begin
                if (flush_cnt_reg == 3'd0) begin
                    run_eval = 1'b1;
                end else if (redirect) begin
                    flush_cnt_next = FLUSH_LOAD;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 3'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    state_next   = lu_pend_reg ? LU_STALL : RUN;
                    lu_pend_next = 1'b0;
                end
            end
            HALT: begin
                if (resume) state_next = RUN;
            end
            default: state_next = RUN;
        endcase

        // Shared priority chain: ecb > redirect > memory wait > load-use.
        if (run_eval) begin
            if (ex_ecb) begin
                state_next = HALT;
            end else if (redirect) begin
                state_next     = FLUSH;
                flush_cnt_next = FLUSH_LOAD;
            end else if (dmem_req && !dmem_ack) begin
                state_next   = MEM_WAIT;
                lu_pend_next = lu;
            end else if (lu && state_reg != LU_STALL) begin
                state_next = LU_STALL;
            end else begin
                state_next = RUN;
            end
        end
    end

    always_comb begin
        pc_en     = 1'b0;
        dec_clkEn = 1'b0;
        dec_jmp   = 1'b0;
        ex_hold   = 1'b0;
        stall     = 1'b0;
        halted    = 1'b0;
        if (rstB) begin
            case (state_next)
                RUN: begin
                    pc_en     = 1'b1;
                    dec_clkEn = 1'b1;
                end
                LU_STALL: stall = 1'b1;
                FLUSH: begin
                    pc_en     = 1'b1;
                    dec_clkEn = 1'b1;
                    dec_jmp   = 1'b1;
                end
                MEM_WAIT: begin
                    ex_hold = 1'b1;
                    stall   = 1'b1;
                end
                HALT: begin
                    stall  = 1'b1;
                    halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            state_reg     <= RUN;
            flush_cnt_reg <= 3'd0;
            lu_pend_reg   <= 1'b0;
            stall_count   <= '0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            lu_pend_reg   <= lu_pend_next;
            if (stall && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl (FLUSH_CYCLES=2, CNT_W=4).
module tb_pipe_ctrl;
    logic       clk = 1'b0;
    logic       rstB;
    logic       imem_valid, ex_op_memLd, redirect, dmem_req, dmem_ack, ex_ecb, resume;
    logic [4:0] if_reg_s1, if_reg_s2, ex_reg_d;
    logic       pc_en, dec_clkEn, dec_jmp, ex_hold, stall, halted;
    logic [3:0] stall_count;
    logic [5:0] outs;

    int checks   = 0;
    int failures = 0;

    // {pc_en, dec_clkEn, dec_jmp, ex_hold, stall, halted}
    localparam logic [5:0] O_RUN = 6'b110000;
    localparam logic [5:0] O_LU  = 6'b000010;
    localparam logic [5:0] O_FL  = 6'b111000;
    localparam logic [5:0] O_MW  = 6'b000110;
    localparam logic [5:0] O_HT  = 6'b000011;
    localparam logic [5:0] O_RST = 6'b000000;

    assign outs = {pc_en, dec_clkEn, dec_jmp, ex_hold, stall, halted};

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rstB(rstB), .imem_valid(imem_valid),
        .if_reg_s1(if_reg_s1), .if_reg_s2(if_reg_s2),
        .ex_op_memLd(ex_op_memLd), .ex_reg_d(ex_reg_d), .redirect(redirect),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .ex_ecb(ex_ecb), .resume(resume),
        .pc_en(pc_en), .dec_clkEn(dec_clkEn), .dec_jmp(dec_jmp), .ex_hold(ex_hold),
        .stall(stall), .halted(halted), .stall_count(stall_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        imem_valid = 0; ex_op_memLd = 0; redirect = 0; dmem_req = 0;
        dmem_ack = 0; ex_ecb = 0; resume = 0;
        if_reg_s1 = 0; if_reg_s2 = 0; ex_reg_d = 0;
    endtask

    task automatic set_lu;
        imem_valid = 1; ex_op_memLd = 1; ex_reg_d = 5'd5; if_reg_s1 = 5'd0; if_reg_s2 = 5'd5;
    endtask

    task automatic do_reset;
        idle_inputs();
        rstB = 0;
        tick(); tick();
        rstB = 1;
    endtask

    task automatic test_reset;
        rstB = 0;
        for (int i = 0; i < 3; i++) begin
            {imem_valid, ex_op_memLd, redirect, dmem_req, dmem_ack, ex_ecb, resume} = 7'($urandom);
            if_reg_s1 = 5'($urandom); if_reg_s2 = 5'($urandom); ex_reg_d = 5'($urandom);
            @(negedge clk);
            checks++;
            if (outs !== O_RST) begin
                failures++;
                $display("FAIL reset_outs[%0d]: got %b want %b", i, outs, O_RST);
            end
            tick();
        end
        checks++;
        if (stall_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d want 0", stall_count);
        end
        idle_inputs();
        rstB = 1;
        @(negedge clk);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL reset_run: got %b want %b", outs, O_RUN); end
        tick();
        $display("test_reset done");
    endtask

    task automatic test_load_use;
        do_reset();
        set_lu();
        @(negedge clk);
        checks++;
        if (outs !== O_LU) begin failures++; $display("FAIL lu_stall: got %b want %b", outs, O_LU); end
        tick();
        @(negedge clk);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL lu_release: got %b want %b", outs, O_RUN); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (stall_count !== 4'd1) begin failures++; $display("FAIL lu_count: got %0d want 1", stall_count); end
        ex_op_memLd = 1; imem_valid = 1; ex_reg_d = 5'd0;
        @(negedge clk);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL lu_x0: got %b want %b", outs, O_RUN); end
        ex_reg_d = 5'd7; if_reg_s1 = 5'd7; imem_valid = 0;
        #1;
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL lu_invalid: got %b want %b", outs, O_RUN); end
        imem_valid = 1;
        #1;
        checks++;
        if (outs !== O_LU) begin failures++; $display("FAIL lu_rs1: got %b want %b", outs, O_LU); end
        tick();
        idle_inputs();
        $display("test_load_use done");
    endtask

    task automatic test_redirect;
        do_reset();
        redirect = 1;
        @(negedge clk);
        checks++;
        if (outs !== O_FL) begin failures++; $display("FAIL rd_c0: got %b want %b", outs, O_FL); end
        tick();
        redirect = 0; ex_ecb = 1;
        @(negedge clk);
        checks++;
        if (outs !== O_FL) begin failures++; $display("FAIL rd_c1_ecb_ignored: got %b want %b", outs, O_FL); end
        tick();
        ex_ecb = 0;
        @(negedge clk);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL rd_end: got %b want %b", outs, O_RUN); end
        tick();
        redirect = 1;
        tick();
        @(negedge clk);
        checks++;
        if (outs !== O_FL) begin failures++; $display("FAIL rd2_c1: got %b want %b", outs, O_FL); end
        tick();
        redirect = 0;
        @(negedge clk);
        checks++;
        if (outs !== O_FL) begin failures++; $display("FAIL rd2_c2: got %b want %b", outs, O_FL); end
        tick();
        @(negedge clk);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL rd2_end: got %b want %b", outs, O_RUN); end
        checks++;
        if (stall_count !== 4'd0) begin failures++; $display("FAIL rd_count: got %0d want 0", stall_count); end
        tick();
        $display("test_redirect done");
    endtask

    task automatic test_mem_wait;
        do_reset();
        dmem_req = 1; dmem_ack = 1;
        @(negedge clk);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL mem_zero_wait: got %b want %b", outs, O_RUN); end
        tick();
        dmem_ack = 0; set_lu();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== O_MW) begin failures++; $display("FAIL mem_wait[%0d]: got %b want %b", i, outs, O_MW); end
            tick();
            idle_inputs();
            redirect = (i == 0);
        end
        redirect = 0; dmem_ack = 1;
        @(negedge clk);
        checks++;
        if (outs !== O_LU) begin failures++; $display("FAIL mem_lu_pend: got %b want %b", outs, O_LU); end
        tick();
        dmem_ack = 0;
        @(negedge clk);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL mem_end: got %b want %b", outs, O_RUN); end
        checks++;
        if (stall_count !== 4'd4) begin failures++; $display("FAIL mem_count: got %0d want 4", stall_count); end
        tick();
        $display("test_mem_wait done");
    endtask

    task automatic test_priority;
        do_reset();
        redirect = 1; dmem_req = 1;
        @(negedge clk);
        checks++;
        if (outs !== O_FL) begin failures++; $display("FAIL pri_rd_over_mem: got %b want %b", outs, O_FL); end
        do_reset();
        resume = 1;
        @(negedge clk);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL pri_resume_in_run: got %b want %b", outs, O_RUN); end
        resume = 0; ex_ecb = 1; redirect = 1; set_lu();
        #1;
        checks++;
        if (outs !== O_HT) begin failures++; $display("FAIL pri_halt: got %b want %b", outs, O_HT); end
        tick();
        idle_inputs(); redirect = 1; dmem_req = 1;
        @(negedge clk);
        checks++;
        if (outs !== O_HT) begin failures++; $display("FAIL pri_halt_hold: got %b want %b", outs, O_HT); end
        tick();
        idle_inputs(); resume = 1;
        @(negedge clk);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL pri_resume: got %b want %b", outs, O_RUN); end
        tick();
        resume = 0;
        @(negedge clk);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL pri_after_resume: got %b want %b", outs, O_RUN); end
        tick();
        $display("test_priority done");
    endtask

    task automatic test_saturation;
        do_reset();
        ex_ecb = 1;
        tick();
        ex_ecb = 0;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        checks++;
        if (stall_count !== 4'd5) begin failures++; $display("FAIL sat_partial: got %0d want 5", stall_count); end
        for (int i = 0; i < 16; i++) tick();
        @(negedge clk);
        checks++;
        if (stall_count !== 4'd15) begin failures++; $display("FAIL sat_count: got %0d want 15", stall_count); end
        checks++;
        if (outs !== O_HT) begin failures++; $display("FAIL sat_halted: got %b want %b", outs, O_HT); end
        $display("test_saturation done");
    endtask

    task automatic test_reset_midwait;
        do_reset();
        dmem_req = 1;
        tick();
        dmem_req = 0;
        tick();
        rstB = 0; dmem_ack = 1;
        @(negedge clk);
        checks++;
        if (outs !== O_RST) begin failures++; $display("FAIL rstwait_outs: got %b want %b", outs, O_RST); end
        tick();
        rstB = 1;
        @(negedge clk);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL rstwait_run: got %b want %b", outs, O_RUN); end
        checks++;
        if (stall_count !== 4'd0) begin failures++; $display("FAIL rstwait_count: got %0d want 0", stall_count); end
        tick();
        idle_inputs();
        $display("test_reset_midwait done");
    endtask

    initial begin
        idle_inputs();
        rstB = 0;
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_priority();
        test_saturation();
        test_reset_midwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the RV32I core. It sits between fetch, the instruction decoder and the execute/memory stage, and drives the decoder's `clkEn` and `jmp` inputs, the PC advance enable and the execute-stage hold. It also detects load-use hazards, redirect flushes, multi-cycle data-memory waits and ecall/ebreak halts. A saturating stall-cycle counter is provided for performance monitoring.

## Interface
Parameters:
- FLUSH_CYCLES, default 2: number of cycles decode is squashed after a redirect; legal range 1..7.
- CNT_W, default 16: width of the stall counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rstB  in  1  reset, synchronous, active-low
- imem_valid  in  1  fetch is presenting a valid instruction to decode this cycle
- if_reg_s1  in  5  rs1 field of the instruction entering decode
- if_reg_s2  in  5  rs2 field of the instruction entering decode
- ex_op_memLd  in  1  instruction in execute is a load
- ex_reg_d  in  5  rd of the instruction in execute
- redirect  in  1  taken branch, jal or jalr resolved in execute; single-cycle pulse
- dmem_req  in  1  execute issues a data-memory access this cycle
- dmem_ack  in  1  data memory completes the outstanding access
- ex_ecb  in  1  ecall/ebreak is in execute
- resume  in  1  release from HALT
- pc_en  out  1  PC/fetch may advance
- dec_clkEn  out  1  drives the decoder's clkEn; 0 makes decode emit a bubble
- dec_jmp  out  1  drives the decoder's jmp; flushes decode
- ex_hold  out  1  freeze the execute/memory stage registers
- stall  out  1  any stall cycle (LU_STALL, MEM_WAIT, HALT)
- halted  out  1  controller is in HALT
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- States: RUN, LU_STALL, FLUSH, MEM_WAIT, HALT. Encoded in 3 bits. The state register resets to RUN.
- Hazard term: lu = imem_valid & ex_op_memLd & (ex_reg_d != 0) & ((ex_reg_d == if_reg_s1) | (ex_reg_d == if_reg_s2)).
- next_state is combinational. pc_en, dec_clkEn, dec_jmp, ex_hold, stall and halted are combinational decodes of next_state, so a condition affects the same cycle in which it is detected.
- From RUN or LU_STALL, first match wins:
  - ex_ecb → HALT.
  - redirect → FLUSH, with flush_cnt loaded to FLUSH_CYCLES-1.
  - dmem_req & !dmem_ack → MEM_WAIT. If lu is also true in this cycle, lu_pend is set to 1.
  - lu, evaluated in RUN only → LU_STALL.
  - Otherwise → RUN.
- FLUSH: flush_cnt decrements each cycle. At flush_cnt==0 evaluation follows the RUN rules; otherwise the state stays FLUSH. Redirect while in FLUSH reloads flush_cnt. ex_ecb and dmem_req are ignored in FLUSH, because execute holds only bubbles.
- MEM_WAIT: stays until dmem_ack.
  - On dmem_ack with lu_pend=1 → LU_STALL, and lu_pend clears.
  - On dmem_ack with lu_pend=0 → RUN.
  - redirect, ex_ecb and lu are ignored in this state.
- HALT: stays until resume, then → RUN. All other inputs are ignored.
- Output decode by next_state:
  - RUN: pc_en=1, dec_clkEn=1, all others 0.
  - LU_STALL: pc_en=0, dec_clkEn=0, stall=1. Fetch holds the dependent instruction, which re-enters decode in the next RUN cycle.
  - FLUSH: pc_en=1, dec_clkEn=1, dec_jmp=1.
  - MEM_WAIT: pc_en=0, dec_clkEn=0, ex_hold=1, stall=1.
  - HALT: pc_en=0, dec_clkEn=0, stall=1, halted=1.
- stall_count increments by 1 on every edge where stall=1 and rstB=1. It saturates at 2^CNT_W-1 and never wraps.

## Timing
- Reset: while rstB=0, all outputs are forced to 0, including pc_en and dec_clkEn. On the first edge after rstB=1 the state is RUN, flush_cnt=0, lu_pend=0 and stall_count=0.
- Reset asserted mid-MEM_WAIT or mid-FLUSH: the next edge returns the controller to RUN. A pending dmem_ack after reset is ignored.
- Load-use costs exactly 1 bubble cycle when dmem_ack arrives in the same cycle as dmem_req.
- A redirect costs FLUSH_CYCLES cycles with dec_jmp=1.
- MEM_WAIT lasts N cycles for an ack arriving N cycles after the request. If lu_pend is set, 1 extra LU_STALL cycle follows.
- Simultaneous inputs follow the priority order above: ecb > redirect > mem wait > load-use.
- dmem_req with dmem_ack in the same cycle is a zero-wait access and causes no state change.
- resume asserted while not in HALT has no effect.

## Test plan
- Reset: hold rstB=0 for 3 cycles with random inputs → every output is 0. After release, the state is RUN, pc_en=1, dec_clkEn=1 and stall_count=0.
- Load-use: ex_op_memLd=1, ex_reg_d=5, if_reg_s2=5, imem_valid=1 → exactly one cycle with pc_en=0, dec_clkEn=0, stall=1, then RUN. Repeat with ex_reg_d=0 → no stall.
- Redirect with FLUSH_CYCLES=2: redirect pulse → dec_jmp=1 for 2 cycles. A second redirect in flush cycle 2 → dec_jmp stays 1 for 2 more cycles.
- Memory wait plus hazard: dmem_req=1 with lu true, ack after 3 cycles → ex_hold=1 for 3 cycles, then 1 LU_STALL cycle, then RUN. stall_count increases by 4.
- Priority: ex_ecb=1, redirect=1 and lu true in the same cycle → HALT, halted=1, pc_en=0. resume=1 → RUN on the next cycle.
- Saturation with CNT_W=4: hold HALT for 20 cycles → stall_count stops at 15.
